// File: rtl/playback_controller_if.sv
// Control bundle between the button/reader side and the playback sequencer.
// The controller takes the slave modport; whatever drives the buttons takes master.
interface playback_controller_if;
    logic       play_button;
    logic       next_button;
    logic       prev_button;
    logic       repeat_mode;
    logic       song_done;
    logic       play;
    logic       reset_player;
    logic [1:0] song;
    logic       beat;

    modport master (
        output play_button, next_button, prev_button, repeat_mode, song_done,
        input  play, reset_player, song, beat
    );

    modport slave (
        input  play_button, next_button, prev_button, repeat_mode, song_done,
        output play, reset_player, song, beat
    );
endinterface

// File: rtl/playback_controller.sv
// Music player sequencer: maps button pulses and song_done onto play/reset_player/song,
// applies auto-advance and repeat policy, and paces note timing with a beat strobe.
module playback_controller #(
    parameter int unsigned NUM_SONGS = 4,
    parameter int unsigned BEAT_DIV  = 1000
) (
    input logic                 clk,
    input logic                 reset,
    playback_controller_if.slave bus
);
    localparam int unsigned     CntW      = $clog2(BEAT_DIV);
    localparam logic [1:0]      LastSong  = 2'(NUM_SONGS - 1);
    localparam logic [CntW-1:0] LastCount = CntW'(BEAT_DIV - 1);

    typedef enum logic [1:0] {StInit, StPaused, StPlaying, StSwitch} state_e;

    state_e          state_q;
    logic [1:0]      song_q;
    logic            resume_q;
    logic [CntW-1:0] count_q;
    logic [1:0]      song_inc;
    logic [1:0]      song_dec;
    logic            play_w;
    logic            clear_w;

    assign song_inc = (song_q == LastSong) ? 2'd0 : song_q + 2'd1;
    assign song_dec = (song_q == 2'd0) ? LastSong : song_q - 2'd1;
    assign play_w   = (state_q == StPlaying);
    assign clear_w  = (state_q == StInit) || (state_q == StSwitch);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StInit;
            song_q   <= 2'd0;
            resume_q <= 1'b0;
            count_q  <= '0;
        end else begin
            // Counter holds while paused so a resumed song continues mid-beat.
            if (clear_w) begin
                count_q <= '0;
            end else if (play_w) begin
                count_q <= (count_q == LastCount) ? '0 : count_q + 1'b1;
            end

            case (state_q)
                StInit: state_q <= StPaused;
                StPaused: begin
                    if (bus.next_button) begin
                        song_q   <= song_inc;
                        resume_q <= 1'b0;
                        state_q  <= StSwitch;
                    end else if (bus.prev_button) begin
                        song_q   <= song_dec;
                        resume_q <= 1'b0;
                        state_q  <= StSwitch;
                    end else if (bus.play_button) begin
                        state_q <= StPlaying;
                    end
                end
                StPlaying: begin
                    if (bus.next_button) begin
                        song_q   <= song_inc;
                        resume_q <= 1'b1;
                        state_q  <= StSwitch;
                    end else if (bus.prev_button) begin
                        song_q   <= song_dec;
                        resume_q <= 1'b1;
                        state_q  <= StSwitch;
                    end else if (bus.play_button) begin
                        state_q <= StPaused;
                    end else if (bus.song_done) begin
                        // Running off the end of the playlist rewinds and stops.
                        if (bus.repeat_mode) begin
                            resume_q <= 1'b1;
                        end else if (song_q != LastSong) begin
                            song_q   <= song_q + 2'd1;
                            resume_q <= 1'b1;
                        end else begin
                            song_q   <= 2'd0;
                            resume_q <= 1'b0;
                        end
                        state_q <= StSwitch;
                    end
                end
                StSwitch: state_q <= resume_q ? StPlaying : StPaused;
                default:  state_q <= StInit;
            endcase
        end
    end

    assign bus.play         = play_w;
    assign bus.reset_player = clear_w;
    assign bus.song         = song_q;
    assign bus.beat         = play_w && (count_q == LastCount);
endmodule

// File: tb/tb_playback_controller.sv
// Bench for playback_controller: directed scenarios with literal expectations plus a random
// phase, all outputs compared every cycle against a behavioural player model.
module tb_playback_controller;
    localparam int unsigned NUM_SONGS = 4;
    localparam int unsigned BEAT_DIV  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    playback_controller_if bus();

    playback_controller #(
        .NUM_SONGS(NUM_SONGS),
        .BEAT_DIV (BEAT_DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Player model: booting, switching track, playing or paused, and play-time within a beat.
    bit m_booting, m_switching, m_playing, m_resume;
    int m_song, m_phase;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_booting = 1; m_switching = 0; m_playing = 0; m_resume = 0;
            m_song = 0; m_phase = 0;
        end else if (m_booting) begin
            m_booting = 0; m_playing = 0; m_phase = 0;
        end else if (m_switching) begin
            m_switching = 0; m_playing = m_resume; m_phase = 0;
        end else begin
            if (m_playing) m_phase = (m_phase + 1) % BEAT_DIV;
            if (bus.next_button) begin
                m_song = (m_song + 1) % NUM_SONGS;
                m_resume = m_playing; m_switching = 1;
            end else if (bus.prev_button) begin
                m_song = (m_song + NUM_SONGS - 1) % NUM_SONGS;
                m_resume = m_playing; m_switching = 1;
            end else if (bus.play_button) begin
                m_playing = !m_playing;
            end else if (bus.song_done && m_playing) begin
                if (bus.repeat_mode) m_resume = 1;
                else if (m_song < NUM_SONGS - 1) begin m_song++; m_resume = 1; end
                else begin m_song = 0; m_resume = 0; end
                m_switching = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            bit exp_play;
            exp_play = m_playing && !m_switching && !m_booting;
            check("play", int'(bus.play), int'(exp_play));
            check("reset_player", int'(bus.reset_player), int'(m_booting || m_switching));
            check("song", int'(bus.song), m_song);
            check("beat", int'(bus.beat), int'(exp_play && m_phase == BEAT_DIV - 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.play_button = 0; bus.next_button = 0; bus.prev_button = 0;
        bus.repeat_mode = 0; bus.song_done = 0;
        reset = 1;
        tick(2);
        reset = 0;
        check_en = 1;
        check("lit_init_rp", int'(bus.reset_player), 1);
        check("lit_init_play", int'(bus.play), 0);
        check("lit_init_song", int'(bus.song), 0);
        tick(1);
        check("lit_paused_rp", int'(bus.reset_player), 0);
        tick(20);

        // Beat pacing and pause/resume mid-beat.
        bus.play_button = 1; tick(1); bus.play_button = 0;
        check("lit_play_on", int'(bus.play), 1);
        tick(3);
        check("lit_beat4", int'(bus.beat), 1);
        tick(1);
        check("lit_beat5", int'(bus.beat), 0);
        tick(1);
        bus.play_button = 1; tick(1); bus.play_button = 0;
        check("lit_paused", int'(bus.play), 0);
        tick(3);
        bus.play_button = 1; tick(1); bus.play_button = 0;
        check("lit_resume_b0", int'(bus.beat), 0);
        tick(1);
        check("lit_resume_b1", int'(bus.beat), 1);
        bus.play_button = 1; tick(1); bus.play_button = 0;

        // Song wrap in both directions, next beats prev.
        bus.prev_button = 1; tick(1); bus.prev_button = 0;
        check("lit_prev_wrap", int'(bus.song), 3);
        check("lit_prev_rp", int'(bus.reset_player), 1);
        tick(1);
        check("lit_after_sw_rp", int'(bus.reset_player), 0);
        check("lit_after_sw_play", int'(bus.play), 0);
        bus.next_button = 1; tick(1); bus.next_button = 0;
        check("lit_next_wrap", int'(bus.song), 0);
        tick(1);
        bus.prev_button = 1; tick(1); bus.prev_button = 0;
        tick(1);
        bus.next_button = 1; bus.prev_button = 1; tick(1);
        bus.next_button = 0; bus.prev_button = 0;
        check("lit_next_wins", int'(bus.song), 0);
        tick(1);

        // Auto-advance, repeat, end of playlist.
        bus.next_button = 1; tick(1); bus.next_button = 0;
        tick(1);
        bus.play_button = 1; tick(1); bus.play_button = 0;
        bus.song_done = 1; tick(1);
        check("lit_adv_song", int'(bus.song), 2);
        check("lit_adv_rp", int'(bus.reset_player), 1);
        tick(1); bus.song_done = 0;
        check("lit_adv_play", int'(bus.play), 1);
        bus.repeat_mode = 1; bus.song_done = 1; tick(1); bus.song_done = 0;
        check("lit_rep_song", int'(bus.song), 2);
        tick(1);
        check("lit_rep_play", int'(bus.play), 1);
        bus.repeat_mode = 0;
        bus.next_button = 1; tick(1); bus.next_button = 0;
        tick(1);
        bus.song_done = 1; tick(1);
        check("lit_end_song", int'(bus.song), 0);
        tick(1); bus.song_done = 0;
        check("lit_end_paused", int'(bus.play), 0);
        tick(1);

        // Reset landing on a SWITCH cycle, with a play pulse that must be lost.
        bus.next_button = 1; tick(1); bus.next_button = 0;
        tick(1);
        bus.next_button = 1; tick(1); bus.next_button = 0;
        reset = 1; bus.play_button = 1; tick(1);
        reset = 0; bus.play_button = 0;
        check("lit_rst_song", int'(bus.song), 0);
        check("lit_rst_rp", int'(bus.reset_player), 1);
        tick(1);
        check("lit_rst_paused", int'(bus.play), 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bus.next_button = ($urandom % 16) == 0;
            bus.prev_button = ($urandom % 16) == 0;
            bus.play_button = ($urandom % 6) == 0;
            bus.song_done   = ($urandom % 8) == 0;
            if (($urandom % 50) == 0) bus.repeat_mode = ~bus.repeat_mode;
            reset = ($urandom % 300) == 0;
            tick(1);
        end
        reset = 0;
        bus.next_button = 0; bus.prev_button = 0; bus.play_button = 0; bus.song_done = 0;
        tick(2);
        check_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
